avalon_st_width_downsizer: RTL and testbench
============================================

// Module: avalon_st_width_downsizer
// PURPOSE
//   Avalon-ST data-width downsizer: splits each IN_BYTES-wide input beat into up to
//   IN_BYTES/OUT_BYTES narrower output beats, preserving sop/eop/empty packet framing.
//   Sits between a wide internal datapath and a narrower egress/enforcer stage.
//   Single-beat holding register; full throughput when the output is never stalled.
// PARAMETERS
//   IN_BYTES   16  input data width in bytes; power of 2, >= 4
//   OUT_BYTES  4   output data width in bytes; power of 2, >= 2, IN_BYTES/OUT_BYTES >= 2
//   (R = IN_BYTES/OUT_BYTES; empty widths = log2up_func(N) from general_pack)
// PORTS
//   clk        in   1                      clock; all logic on rising edge
//   rst        in   1                      synchronous, active-high reset
//   in_data    in   IN_BYTES*8             input data; first byte in MS bits [IN_BYTES*8-1 -: 8]
//   in_valid   in   1                      input beat valid
//   in_rdy     out  1                      downsizer can accept a beat this cycle
//   in_sop     in   1                      first beat of packet
//   in_eop     in   1                      last beat of packet
//   in_empty   in   log2up_func(IN_BYTES)  unused LS bytes of in_data; meaningful only with in_eop
//   out_data   out  OUT_BYTES*8            output slice; first byte in MS bits
//   out_valid  out  1                      output beat valid
//   out_rdy    in   1                      downstream accepts out beat
//   out_sop    out  1                      first slice of packet
//   out_eop    out  1                      last slice of packet
//   out_empty  out  log2up_func(OUT_BYTES) unused LS bytes of out_data; nonzero only with out_eop
// BEHAVIOUR
//   - Handshake: transfer on in_valid&in_rdy / out_valid&out_rdy. out_* held stable while
//     out_valid=1 and out_rdy=0. No combinational path in_valid->out_valid.
//   - FSM: IDLE (no beat held) / SEND (beat held, slice index k in 0..n-1).
//     IDLE: in_rdy=1; on accept -> capture data/sop/eop/empty, k=0, SEND.
//     SEND: out_data = slice k (bytes k*OUT_BYTES .. from MS end); on out accept:
//       k<n-1 -> k+1; k=n-1 -> if in_valid&in_rdy capture new beat (k=0, stay SEND) else IDLE.
//   - in_rdy = IDLE | (SEND & k==n-1 & out_rdy): back-to-back beats with zero bubble.
//   - Latency: first slice valid the cycle after input acceptance (1 clk).
//   - Slice count n: non-eop beat -> n=R (in_empty ignored). eop beat -> valid bytes
//     V=IN_BYTES-in_empty; n=ceil(V/OUT_BYTES) (1..R); trailing all-empty slices are dropped.
//   - out_sop = held_sop & k==0. out_eop = held_eop & k==n-1.
//     out_empty = (k==n-1 & held_eop) ? n*OUT_BYTES-V : 0.
//   - A packet may be a single eop+sop beat; both flags then appear on appropriate slices
//     (both on one slice when n=1).
//   - No packet-framing checking; malformed sop/eop sequences are passed through as-is.
//   - Reset (any cycle, incl. mid-packet): FSM->IDLE, k=0, held beat discarded;
//     out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0; in_rdy=0 while rst=1,
//     1 the first cycle after rst deasserts.
// TESTING
//   1. 16->4, one non-eop beat 0x00112233_44556677_8899AABB_CCDDEEFF, out_rdy=1 -> 4 slices
//      0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF on consecutive clks, out_empty=0.
//   2. 16->4, sop+eop beat in_empty=9 (V=7) -> 2 slices, sop on 1st, eop on 2nd,
//      out_empty=1; in_rdy high the cycle the 2nd slice is accepted.
//   3. Continuous in_valid, 3-beat packet (sop, -, eop empty=0), out_rdy=1 -> 12 slices,
//      no idle cycle between beats; in_rdy pattern 1,0,0,0 repeating.
//   4. out_rdy toggling 1,0,0,1... -> out_data/sop/eop/empty stable across stalls, no slice
//      lost or duplicated (scoreboard byte-compare).
//   5. rst=1 while k=2 of a held beat -> next clk out_valid=0, in_rdy=0; after release
//      new packet starts cleanly at slice 0 with out_sop=1.
//   6. 8->2 (R=4), eop beat in_empty=6 (V=2) -> single slice with out_sop/out_eop per
//      input, out_empty=0.

Source files
------------

// File: rtl/avalon_st_width_downsizer_if.sv
// rtl/avalon_st_width_downsizer_if.sv - Avalon-ST beat bundle (data/valid/rdy/sop/eop/empty)
interface avalon_st_width_downsizer_if #(
   parameter int BYTES = 16
);
   localparam int EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [BYTES*8-1:0] data;
   logic               valid;
   logic               rdy;
   logic               sop;
   logic               eop;
   logic [EMPTY_W-1:0] empty;

   modport master (output data, valid, sop, eop, empty, input rdy);
   modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_width_downsizer.sv
// rtl/avalon_st_width_downsizer.sv - Avalon-ST width downsizer, one wide beat into up to IN/OUT narrow slices
module avalon_st_width_downsizer #(
   parameter int IN_BYTES  = 16,
   parameter int OUT_BYTES = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   avalon_st_width_downsizer_if.slave         in_i,
   avalon_st_width_downsizer_if.master        out_o
);
   localparam int R  = IN_BYTES / OUT_BYTES;
   localparam int IW = $clog2(IN_BYTES);
   localparam int OW = $clog2(OUT_BYTES);
   localparam int KW = $clog2(R);
   localparam int SW = OUT_BYTES * 8;

   localparam logic [IW:0] IN_BYTES_W  = (IW+1)'(IN_BYTES);
   localparam logic [IW:0] OUT_ROUND_W = (IW+1)'(OUT_BYTES - 1);
   localparam logic [IW:0] ONE_W       = (IW+1)'(1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q;
   logic [IN_BYTES*8-1:0] hold_q;
   logic [KW-1:0]       k_q;
   logic [KW-1:0]       last_q;
   logic                eop_q;
   logic [OW-1:0]       pad_q;
   logic                out_valid_q;
   logic                out_sop_q;
   logic                out_eop_q;
   logic [OW-1:0]       out_empty_q;

   logic                at_last;
   logic                out_fire;
   logic                in_rdy;
   logic                in_fire;
   logic [KW-1:0]       k_next;

   logic [IW:0]         cap_v;
   logic [IW:0]         cap_n;
   logic [IW:0]         cap_bytes;
   logic [KW-1:0]       cap_last;
   logic [OW-1:0]       cap_pad;

   assign at_last  = (k_q == last_q);
   assign k_next   = k_q + KW'(1);
   assign out_fire = out_valid_q && out_o.rdy;
   assign in_rdy   = !rst && ((state_q == IDLE) ||
                              ((state_q == SEND) && at_last && out_o.rdy));
   assign in_fire  = in_i.valid && in_rdy;

   // Slice count and final-slice padding for the beat being captured;
   // non-eop beats always expand to the full R slices.
   always_comb begin
      cap_v     = in_i.eop ? (IN_BYTES_W - {1'b0, in_i.empty}) : IN_BYTES_W;
      cap_n     = (cap_v + OUT_ROUND_W) >> OW;
      cap_bytes = cap_n << OW;
      cap_last  = KW'(cap_n - ONE_W);
      cap_pad   = OW'(cap_bytes - cap_v);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         k_q         <= '0;
         last_q      <= '0;
         eop_q       <= 1'b0;
         pad_q       <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_empty_q <= '0;
      end else if (in_fire) begin
         state_q     <= SEND;
         hold_q      <= in_i.data;
         k_q         <= '0;
         last_q      <= cap_last;
         eop_q       <= in_i.eop;
         pad_q       <= cap_pad;
         out_valid_q <= 1'b1;
         out_sop_q   <= in_i.sop;
         out_eop_q   <= in_i.eop && (cap_last == '0);
         out_empty_q <= (in_i.eop && (cap_last == '0)) ? cap_pad : '0;
      end else if (out_fire) begin
         if (at_last) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
         end else begin
            // The held beat shifts toward the MS end so the current slice is always on top.
            hold_q      <= hold_q << SW;
            k_q         <= k_next;
            out_sop_q   <= 1'b0;
            out_eop_q   <= eop_q && (k_next == last_q);
            out_empty_q <= (eop_q && (k_next == last_q)) ? pad_q : '0;
         end
      end
   end

   assign in_i.rdy    = in_rdy;
   assign out_o.data  = hold_q[IN_BYTES*8-1 -: SW];
   assign out_o.valid = out_valid_q;
   assign out_o.sop   = out_sop_q;
   assign out_o.eop   = out_eop_q;
   assign out_o.empty = out_empty_q;
endmodule

// File: tb/tb_avalon_st_width_downsizer.sv
// tb/tb_avalon_st_width_downsizer.sv - directed bench for avalon_st_width_downsizer (16->4 and 8->2)
module tb_avalon_st_width_downsizer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   avalon_st_width_downsizer_if #(.BYTES(16)) a_in ();
   avalon_st_width_downsizer_if #(.BYTES(4))  a_out ();
   avalon_st_width_downsizer_if #(.BYTES(8))  b_in ();
   avalon_st_width_downsizer_if #(.BYTES(2))  b_out ();

   avalon_st_width_downsizer #(.IN_BYTES(16), .OUT_BYTES(4)) dut_a (
      .clk   (clk),
      .rst   (rst),
      .in_i  (a_in),
      .out_o (a_out)
   );

   avalon_st_width_downsizer #(.IN_BYTES(8), .OUT_BYTES(2)) dut_b (
      .clk   (clk),
      .rst   (rst),
      .in_i  (b_in),
      .out_o (b_out)
   );

   task automatic test_reset();
      a_in.valid = 0; a_in.data = '0; a_in.sop = 0; a_in.eop = 0; a_in.empty = '0; a_out.rdy = 1;
      b_in.valid = 0; b_in.data = '0; b_in.sop = 0; b_in.eop = 0; b_in.empty = '0; b_out.rdy = 1;
      rst = 1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 0 || a_in.rdy !== 0 || a_out.data !== 0 || a_out.sop !== 0 ||
          a_out.eop !== 0 || a_out.empty !== 0) begin
         bad++;
         $display("FAIL reset_a valid=%b rdy=%b data=%h sop=%b eop=%b empty=%0d exp all zero",
                  a_out.valid, a_in.rdy, a_out.data, a_out.sop, a_out.eop, a_out.empty);
      end
      total++;
      if (b_out.valid !== 0 || b_in.rdy !== 0 || b_out.data !== 0) begin
         bad++;
         $display("FAIL reset_b valid=%b rdy=%b data=%h exp 0 0 0", b_out.valid, b_in.rdy, b_out.data);
      end
      @(negedge clk);
      rst = 0;
      #1;
      total++;
      if (a_in.rdy !== 1 || b_in.rdy !== 1 || a_out.valid !== 0) begin
         bad++;
         $display("FAIL reset_release a_rdy=%b b_rdy=%b a_valid=%b exp 1 1 0", a_in.rdy, b_in.rdy, a_out.valid);
      end
   endtask

   task automatic test_single_beat();
      logic [127:0] beat;
      logic [31:0]  exp;
      beat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      @(negedge clk);
      a_in.data = beat; a_in.valid = 1; a_in.sop = 1; a_in.eop = 0; a_in.empty = 4'd9; a_out.rdy = 1;
      #1;
      total++;
      if (a_in.rdy !== 1) begin
         bad++;
         $display("FAIL t1_accept rdy=%b exp 1", a_in.rdy);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_in.valid = 0;
         #1;
         exp = beat[127-32*i -: 32];
         total++;
         if (a_out.valid !== 1 || a_out.data !== exp || a_out.sop !== (i == 0) ||
             a_out.eop !== 0 || a_out.empty !== 0) begin
            bad++;
            $display("FAIL t1_slice%0d valid=%b data=%h sop=%b eop=%b empty=%0d exp 1 %h %b 0 0",
                     i, a_out.valid, a_out.data, a_out.sop, a_out.eop, a_out.empty, exp, (i == 0));
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 0) begin
         bad++;
         $display("FAIL t1_idle valid=%b exp 0", a_out.valid);
      end
   endtask

   task automatic test_short_eop();
      @(negedge clk);
      a_in.data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      a_in.valid = 1; a_in.sop = 1; a_in.eop = 1; a_in.empty = 4'd9; a_out.rdy = 1;
      @(negedge clk);
      a_in.valid = 0;
      #1;
      total++;
      if (a_out.valid !== 1 || a_out.data !== 32'h00112233 || a_out.sop !== 1 || a_out.eop !== 0 ||
          a_out.empty !== 0 || a_in.rdy !== 0) begin
         bad++;
         $display("FAIL t2_slice0 valid=%b data=%h sop=%b eop=%b empty=%0d rdy=%b exp 1 00112233 1 0 0 0",
                  a_out.valid, a_out.data, a_out.sop, a_out.eop, a_out.empty, a_in.rdy);
      end
      @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 1 || a_out.data !== 32'h44556677 || a_out.sop !== 0 || a_out.eop !== 1 ||
          a_out.empty !== 1 || a_in.rdy !== 1) begin
         bad++;
         $display("FAIL t2_slice1 valid=%b data=%h sop=%b eop=%b empty=%0d rdy=%b exp 1 44556677 0 1 1 1",
                  a_out.valid, a_out.data, a_out.sop, a_out.eop, a_out.empty, a_in.rdy);
      end
      @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 0) begin
         bad++;
         $display("FAIL t2_idle valid=%b exp 0", a_out.valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] beats [3];
      logic [127:0] cur;
      logic [31:0]  exp;
      int bi = 0;
      int s;
      beats[0] = 128'h10111213_14151617_18191A1B_1C1D1E1F;
      beats[1] = 128'h20212223_24252627_28292A2B_2C2D2E2F;
      beats[2] = 128'h30313233_34353637_38393A3B_3C3D3E3F;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         a_out.rdy = 1;
         if (bi < 3) begin
            a_in.valid = 1; a_in.data = beats[bi]; a_in.sop = (bi == 0); a_in.eop = (bi == 2); a_in.empty = '0;
         end else begin
            a_in.valid = 0;
         end
         #1;
         total++;
         if (a_in.rdy !== ((c % 4 == 0) || c == 13)) begin
            bad++;
            $display("FAIL t3_in_rdy c=%0d rdy=%b exp %b", c, a_in.rdy, ((c % 4 == 0) || c == 13));
         end
         if (c >= 1 && c <= 12) begin
            s = c - 1;
            cur = beats[s / 4];
            exp = cur[127-32*(s % 4) -: 32];
            total++;
            if (a_out.valid !== 1 || a_out.data !== exp || a_out.sop !== (s == 0) ||
                a_out.eop !== (s == 11) || a_out.empty !== 0) begin
               bad++;
               $display("FAIL t3_slice%0d valid=%b data=%h sop=%b eop=%b empty=%0d exp 1 %h %b %b 0",
                        s, a_out.valid, a_out.data, a_out.sop, a_out.eop, a_out.empty, exp, (s == 0), (s == 11));
            end
         end else if (c == 13) begin
            total++;
            if (a_out.valid !== 0) begin
               bad++;
               $display("FAIL t3_idle valid=%b exp 0", a_out.valid);
            end
         end
         if (a_in.valid && a_in.rdy) bi++;
      end
      a_in.valid = 0;
   endtask

   task automatic test_stall();
      logic [127:0] beats [2];
      logic [31:0]  exp_d [7];
      logic [31:0]  pd;
      logic         ps, pe, stalled;
      logic [1:0]   pm;
      int bi = 0;
      int oi = 0;
      beats[0] = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      beats[1] = 128'h01020304_05060708_090A0B0C_0D0E0F10;
      exp_d = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0,
                32'h01020304, 32'h05060708, 32'h090A0B0C};
      stalled = 0; pd = '0; ps = 0; pe = 0; pm = '0;
      for (int c = 0; c < 60 && oi < 7; c++) begin
         @(negedge clk);
         a_out.rdy = (c % 4 == 0) || (c % 4 == 3);
         if (bi < 2) begin
            a_in.valid = 1; a_in.data = beats[bi]; a_in.sop = (bi == 0); a_in.eop = (bi == 1);
            a_in.empty = (bi == 1) ? 4'd5 : 4'd0;
         end else begin
            a_in.valid = 0;
         end
         #1;
         if (stalled) begin
            total++;
            if (a_out.valid !== 1 || a_out.data !== pd || a_out.sop !== ps || a_out.eop !== pe ||
                a_out.empty !== pm) begin
               bad++;
               $display("FAIL t4_stable c=%0d valid=%b data=%h sop=%b eop=%b empty=%0d exp 1 %h %b %b %0d",
                        c, a_out.valid, a_out.data, a_out.sop, a_out.eop, a_out.empty, pd, ps, pe, pm);
            end
         end
         if (a_out.valid && a_out.rdy) begin
            total++;
            if (a_out.data !== exp_d[oi] || a_out.sop !== (oi == 0) || a_out.eop !== (oi == 6) ||
                a_out.empty !== ((oi == 6) ? 2'd1 : 2'd0)) begin
               bad++;
               $display("FAIL t4_slice%0d data=%h sop=%b eop=%b empty=%0d exp %h %b %b %0d",
                        oi, a_out.data, a_out.sop, a_out.eop, a_out.empty, exp_d[oi], (oi == 0), (oi == 6),
                        (oi == 6) ? 1 : 0);
            end
            oi++;
         end
         stalled = a_out.valid && !a_out.rdy;
         pd = a_out.data; ps = a_out.sop; pe = a_out.eop; pm = a_out.empty;
         if (a_in.valid && a_in.rdy) bi++;
      end
      a_in.valid = 0;
      a_out.rdy = 1;
      total++;
      if (oi != 7) begin
         bad++;
         $display("FAIL t4_count slices=%0d exp 7", oi);
      end
      @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 0) begin
         bad++;
         $display("FAIL t4_idle valid=%b exp 0", a_out.valid);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      a_in.data = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
      a_in.valid = 1; a_in.sop = 1; a_in.eop = 0; a_in.empty = '0; a_out.rdy = 1;
      @(negedge clk);
      a_in.valid = 0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 1 || a_out.data !== 32'hAAAA0003) begin
         bad++;
         $display("FAIL t5_k2 valid=%b data=%h exp 1 aaaa0003", a_out.valid, a_out.data);
      end
      rst = 1;
      #1;
      total++;
      if (a_in.rdy !== 0) begin
         bad++;
         $display("FAIL t5_rdy_in_rst rdy=%b exp 0", a_in.rdy);
      end
      @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 0 || a_in.rdy !== 0 || a_out.data !== 0 || a_out.sop !== 0 ||
          a_out.eop !== 0 || a_out.empty !== 0) begin
         bad++;
         $display("FAIL t5_after_rst valid=%b rdy=%b data=%h sop=%b eop=%b empty=%0d exp all zero",
                  a_out.valid, a_in.rdy, a_out.data, a_out.sop, a_out.eop, a_out.empty);
      end
      rst = 0;
      a_in.data = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;
      a_in.valid = 1; a_in.sop = 1; a_in.eop = 1; a_in.empty = '0;
      #1;
      total++;
      if (a_in.rdy !== 1) begin
         bad++;
         $display("FAIL t5_rdy_release rdy=%b exp 1", a_in.rdy);
      end
      @(negedge clk);
      a_in.valid = 0;
      #1;
      total++;
      if (a_out.valid !== 1 || a_out.sop !== 1 || a_out.data !== 32'hBBBB0001 || a_out.eop !== 0) begin
         bad++;
         $display("FAIL t5_restart valid=%b sop=%b data=%h eop=%b exp 1 1 bbbb0001 0",
                  a_out.valid, a_out.sop, a_out.data, a_out.eop);
      end
      repeat (4) @(negedge clk);
      #1;
      total++;
      if (a_out.valid !== 0) begin
         bad++;
         $display("FAIL t5_drain valid=%b exp 0", a_out.valid);
      end
   endtask

   task automatic test_narrow();
      logic [15:0] exp_d [4];
      exp_d = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
      @(negedge clk);
      b_in.data = 64'hA1B2C3D4_E5F60718;
      b_in.valid = 1; b_in.sop = 1; b_in.eop = 1; b_in.empty = 3'd6; b_out.rdy = 1;
      @(negedge clk);
      b_in.valid = 0;
      #1;
      total++;
      if (b_out.valid !== 1 || b_out.data !== 16'hA1B2 || b_out.sop !== 1 || b_out.eop !== 1 ||
          b_out.empty !== 0 || b_in.rdy !== 1) begin
         bad++;
         $display("FAIL t6_single valid=%b data=%h sop=%b eop=%b empty=%0d rdy=%b exp 1 a1b2 1 1 0 1",
                  b_out.valid, b_out.data, b_out.sop, b_out.eop, b_out.empty, b_in.rdy);
      end
      @(negedge clk);
      b_in.valid = 1; b_in.sop = 0; b_in.eop = 1; b_in.empty = 3'd1;
      #1;
      total++;
      if (b_out.valid !== 0) begin
         bad++;
         $display("FAIL t6_gap valid=%b exp 0", b_out.valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_in.valid = 0;
         #1;
         total++;
         if (b_out.valid !== 1 || b_out.data !== exp_d[i] || b_out.sop !== 0 || b_out.eop !== (i == 3) ||
             b_out.empty !== (i == 3)) begin
            bad++;
            $display("FAIL t6_slice%0d valid=%b data=%h sop=%b eop=%b empty=%0d exp 1 %h 0 %b %b",
                     i, b_out.valid, b_out.data, b_out.sop, b_out.eop, b_out.empty, exp_d[i], (i == 3), (i == 3));
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (b_out.valid !== 0) begin
         bad++;
         $display("FAIL t6_idle valid=%b exp 0", b_out.valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_short_eop();
      test_back_to_back();
      test_stall();
      test_mid_reset();
      test_narrow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
